// File: rtl/motor_pkg.sv
// Shared state type, width defaults and command-to-magnitude helper for the
// motor PWM channels.
package motor_pkg;

    localparam int CMD_WIDTH_DEF = 10;
    localparam int PWM_BITS_DEF  = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        COAST = 2'd2
    } state_t;

    // Magnitude of a signed command after deadband and saturation. Taking the
    // command as a sign-extended int keeps -2^(N-1) exact (its magnitude is 2^(N-1)).
    function automatic int sat_mag(
        input int cmd_val,
        input int deadband,
        input int max_duty
    );
        int mag;
        mag = (cmd_val < 0) ? -cmd_val : cmd_val;
        if (mag < deadband) begin
            return 0;
        end
        if (mag > max_duty) begin
            return max_duty;
        end
        return mag;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus PWM period counter; reusable by every motor channel.
// clear holds the whole timebase at zero so a channel can restart a period.
module pwm_timebase #(
    parameter int PWM_BITS = 9,
    parameter int PRESCALE = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear,
    output logic                tick,
    output logic [PWM_BITS-1:0] cnt,
    output logic                period_start
);

    logic [PWM_BITS-1:0] cnt_reg;
    logic                period_start_reg;

    generate
        if (PRESCALE > 1) begin : g_prescale
            localparam int PRE_W = $clog2(PRESCALE);
            logic [PRE_W-1:0] pre_reg;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    pre_reg <= '0;
                end else if (clear || (pre_reg == PRE_W'(PRESCALE - 1))) begin
                    pre_reg <= '0;
                end else begin
                    pre_reg <= pre_reg + 1'b1;
                end
            end

            assign tick = !clear && (pre_reg == PRE_W'(PRESCALE - 1));
        end else begin : g_no_prescale
            assign tick = !clear;
        end
    endgenerate

    // The period counter wraps naturally; the pulse marks the first cycle at cnt 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_reg          <= '0;
            period_start_reg <= 1'b0;
        end else if (clear) begin
            cnt_reg          <= '0;
            period_start_reg <= 1'b0;
        end else begin
            period_start_reg <= tick && (&cnt_reg);
            if (tick) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign cnt          = cnt_reg;
    assign period_start = period_start_reg;

endmodule

// File: rtl/motor_pwm_driver.sv
// One H-bridge channel: PID command -> deadbanded/saturated duty, direction,
// brake and PWM. Define SLEW_LIMIT_EN to rate-limit duty changes per period.
module motor_pwm_driver
    import motor_pkg::*;
#(
    parameter int CMD_WIDTH   = CMD_WIDTH_DEF,
    parameter int PWM_BITS    = PWM_BITS_DEF,
    parameter int PRESCALE    = 4,
    parameter int MAX_DUTY    = 480,
    parameter int DEADBAND    = 8,
    parameter int SLEW_STEP   = 16,
    parameter int REV_PERIODS = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [CMD_WIDTH-1:0] cmd,
    input  logic                 cmd_valid,
    output logic                 pwm,
    output logic                 dir,
    output logic                 brake,
    output logic [PWM_BITS-1:0]  duty,
    output logic                 period_start
);

`ifdef SLEW_LIMIT_EN
    localparam bit SLEW_EN = 1'b1;
`else
    localparam bit SLEW_EN = 1'b0;
`endif

    // Without slew limiting a step wider than the duty range reaches the target at once.
    localparam int                EFF_STEP = SLEW_EN ? SLEW_STEP : (1 << PWM_BITS);
    localparam logic [PWM_BITS:0] STEP_W   = (PWM_BITS + 1)'(EFF_STEP);
    localparam int                COAST_W  = $clog2(REV_PERIODS + 1);

    state_t               state_reg;
    logic [PWM_BITS-1:0]  tgt_mag_reg;
    logic                 tgt_dir_reg;
    logic [PWM_BITS-1:0]  duty_reg;
    logic                 dir_reg;
    logic                 pwm_reg;
    logic                 brake_reg;
    logic [COAST_W-1:0]   coast_reg;

    logic                 tb_clear;
    logic                 tick;
    logic [PWM_BITS-1:0]  cnt;
    logic                 boundary;
    logic [PWM_BITS-1:0]  cap_mag;
    logic [PWM_BITS-1:0]  eff_mag;
    logic                 eff_dir;

    function automatic logic [PWM_BITS-1:0] step_toward(
        input logic [PWM_BITS-1:0] cur,
        input logic [PWM_BITS-1:0] tgt
    );
        logic [PWM_BITS:0] cur_w;
        logic [PWM_BITS:0] tgt_w;
        logic [PWM_BITS:0] next_w;
        cur_w = {1'b0, cur};
        tgt_w = {1'b0, tgt};
        if (tgt_w > cur_w) begin
            next_w = cur_w + STEP_W;
            if (next_w > tgt_w) begin
                next_w = tgt_w;
            end
        end else if ((cur_w - tgt_w) > STEP_W) begin
            next_w = cur_w - STEP_W;
        end else begin
            next_w = tgt_w;
        end
        return next_w[PWM_BITS-1:0];
    endfunction

    assign tb_clear = (state_reg == IDLE);

    pwm_timebase #(
        .PWM_BITS (PWM_BITS),
        .PRESCALE (PRESCALE)
    ) u_timebase (
        .clock        (clock),
        .reset        (reset),
        .clear        (tb_clear),
        .tick         (tick),
        .cnt          (cnt),
        .period_start (period_start)
    );

    assign boundary = tick && (&cnt);

    // A strobe in the boundary cycle is visible to the FSM in that same cycle.
    always_comb begin
        cap_mag = PWM_BITS'(sat_mag(int'($signed(cmd)), DEADBAND, MAX_DUTY));
        eff_mag = tgt_mag_reg;
        eff_dir = tgt_dir_reg;
        if (cmd_valid) begin
            eff_mag = cap_mag;
            if (cap_mag != '0) begin
                eff_dir = ~cmd[CMD_WIDTH-1];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            tgt_mag_reg <= '0;
            tgt_dir_reg <= 1'b1;
            duty_reg    <= '0;
            dir_reg     <= 1'b1;
            pwm_reg     <= 1'b0;
            brake_reg   <= 1'b1;
            coast_reg   <= '0;
        end else begin
            tgt_mag_reg <= eff_mag;
            tgt_dir_reg <= eff_dir;
            if (!enable) begin
                state_reg <= IDLE;
                duty_reg  <= '0;
                pwm_reg   <= 1'b0;
                brake_reg <= 1'b1;
                coast_reg <= '0;
            end else begin
                pwm_reg <= (state_reg == DRIVE) && (cnt < duty_reg);
                case (state_reg)
                    IDLE: begin
                        state_reg <= DRIVE;
                        dir_reg   <= eff_dir;
                        duty_reg  <= '0;
                        brake_reg <= 1'b0;
                        coast_reg <= '0;
                    end
                    DRIVE: begin
                        if (boundary) begin
                            if ((eff_dir != dir_reg) && (eff_mag != '0)) begin
                                state_reg <= COAST;
                                duty_reg  <= '0;
                                coast_reg <= '0;
                            end else begin
                                duty_reg <= step_toward(duty_reg, eff_mag);
                            end
                        end
                    end
                    COAST: begin
                        // The coast always runs its full length, even if the target flips back.
                        if (boundary) begin
                            if (coast_reg == COAST_W'(REV_PERIODS - 1)) begin
                                state_reg <= DRIVE;
                                dir_reg   <= eff_dir;
                                duty_reg  <= step_toward('0, eff_mag);
                                coast_reg <= '0;
                            end else begin
                                coast_reg <= coast_reg + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        duty_reg  <= '0;
                        brake_reg <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign pwm   = pwm_reg;
    assign dir   = dir_reg;
    assign brake = brake_reg;
    assign duty  = duty_reg;

endmodule
